// File: rtl/modulo_escalonador_pkg.sv
// rtl/modulo_escalonador_pkg.sv - shared types, default widths and the wrap-around arbiter search
package modulo_escalonador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int DIV_W_DEF = 20;

  // First set bit of vec[n-1:0] scanning upward from ptr with wrap; returns ptr if vec is empty.
  function automatic logic [2:0] first_set_from(input logic [7:0] vec, input logic [2:0] ptr,
                                                input int n);
    logic [2:0] w_res;
    logic [3:0] w_idx;
    logic       w_found;
    w_res   = ptr;
    w_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_idx = {1'b0, ptr} + 4'(i);
      if (w_idx >= 4'(n)) w_idx = w_idx - 4'(n);
      if (i < n && !w_found && vec[w_idx[2:0]]) begin
        w_res   = w_idx[2:0];
        w_found = 1'b1;
      end
    end
    return w_res;
  endfunction

endpackage

// File: rtl/modulo_prescaler_tick.sv
// rtl/modulo_prescaler_tick.sv - free-running prescaler producing a registered one-cycle tick
module modulo_prescaler_tick
  import modulo_escalonador_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] tap_sel,
  output logic       tick
);

  logic [DIV_W-1:0] r_pre;
  logic             r_tick;
  logic [4:0]       w_tap;
  logic [DIV_W-1:0] w_mask;

  assign w_tap = (int'(tap_sel) >= DIV_W) ? 5'(DIV_W - 1) : tap_sel;

  // Low (tap+1) bits all ones marks the last cycle of a 2^(tap+1) period.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DIV_W; i++) w_mask[i] = (5'(i) <= w_tap);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= r_pre + DIV_W'(1);
      r_tick <= ((r_pre & w_mask) == w_mask);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/modulo_escalonador_temporizador.sv
// rtl/modulo_escalonador_temporizador.sv - shared timed down-counter with arbiter; MODULO_ESCALONADOR_PRIO_FIXA_EN selects fixed priority
module modulo_escalonador_temporizador
  import modulo_escalonador_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [4:0]             tap_sel,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] dur,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   tick
);

  state_t           r_state;
  logic [2:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic             r_busy;

  logic             w_tick;
  logic [2:0]       w_pick;
  logic [7:0]       w_req8;
  logic             w_req_held;
  logic [CNT_W-1:0] w_dur_sel;

  modulo_prescaler_tick #(.DIV_W(DIV_W)) u_prescaler (
    .clk     (clk),
    .clr     (clr),
    .tap_sel (tap_sel),
    .tick    (w_tick)
  );

  assign w_req8 = 8'(req);

`ifdef MODULO_ESCALONADOR_PRIO_FIXA_EN
  assign w_pick = first_set_from(w_req8, 3'd0, N_REQ);
`else
  logic [2:0] r_rr_ptr;
  logic [2:0] w_sel_nxt;
  assign w_pick    = first_set_from(w_req8, r_rr_ptr, N_REQ);
  assign w_sel_nxt = (r_sel == 3'(N_REQ - 1)) ? 3'd0 : r_sel + 3'd1;
`endif

  // r_gnt is one-hot on r_sel, so this is req[r_sel] without an out-of-range index.
  assign w_req_held = |(req & r_gnt);
  assign w_dur_sel  = dur[int'(r_sel)*CNT_W +: CNT_W];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_sel   <= 3'd0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
`ifndef MODULO_ESCALONADOR_PRIO_FIXA_EN
      r_rr_ptr <= 3'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req != '0) begin
            r_sel   <= w_pick;
            r_gnt   <= N_REQ'(1) << w_pick;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_cnt <= w_dur_sel;
          if (w_dur_sel == '0) begin
            r_done  <= r_gnt;
            r_state <= DONE;
          end else begin
            r_state <= COUNT;
          end
        end
        COUNT: begin
          // A dropped request beats a coincident tick: no done is issued.
          if (!w_req_held) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
`ifndef MODULO_ESCALONADOR_PRIO_FIXA_EN
            r_rr_ptr <= w_sel_nxt;
`endif
          end else if (w_tick && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_done  <= r_gnt;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
`ifndef MODULO_ESCALONADOR_PRIO_FIXA_EN
          r_rr_ptr <= w_sel_nxt;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign busy = r_busy;
  assign tick = w_tick;

endmodule

// File: tb/tb_modulo_escalonador_temporizador.sv
// tb/tb_modulo_escalonador_temporizador.sv - scoreboard bench for the shared timer scheduler
module tb_modulo_escalonador_temporizador;

  localparam int N = 4;
  localparam int CW = 8;
  localparam int DW = 10;

  typedef struct {
    int idx;
    int dur;
  } exp_t;

  logic           clk = 1'b0;
  logic           clr;
  logic [4:0]     tap_sel;
  logic [N-1:0]   req;
  logic [N*CW-1:0] dur;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic           tick;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   mptr = 0;

  modulo_escalonador_temporizador #(.N_REQ(N), .CNT_W(CW), .DIV_W(DW)) dut (
    .clk     (clk),
    .clr     (clr),
    .tap_sel (tap_sel),
    .req     (req),
    .dur     (dur),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  // Arbitration policy of the reference: who is served next out of mask m.
  function automatic int pick(input logic [N-1:0] m, input int p);
`ifdef MODULO_ESCALONADOR_PRIO_FIXA_EN
    for (int i = 0; i < N; i++) if (m[i]) return i;
`else
    for (int i = 0; i < N; i++) if (m[(p + i) % N]) return (p + i) % N;
`endif
    return -1;
  endfunction

  task automatic push_exp(input int k, input int d);
    exp_t e;
    e.idx = k;
    e.dur = d;
    sb.push_back(e);
    mptr = (k + 1) % N;
  endtask

  task automatic set_dur(input int i, input int d);
    dur[i*CW +: CW] = CW'(d);
  endtask

  // Requesters hold req until done; hold_limit>0 keeps all held until that many dones.
  task automatic serve(input int hold_limit, input int budget);
    int  n;
    int  nd;
    bit  ok;
    n = 0; nd = 0; ok = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (done != '0) begin
        nd++;
        if (hold_limit == 0) req = req & ~done;
        else if (nd >= hold_limit) req = '0;
      end
      if (req == '0 && !busy && done == '0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("serve_finished", 32'(ok), 32'd1);
    chk("scoreboard_empty", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_gnt(input logic [N-1:0] g, input int budget);
    int n;
    n = 0;
    while (n < budget && gnt != g) begin
      @(negedge clk);
      n++;
    end
    chk("wait_gnt", 32'(gnt), 32'(g));
  endtask

  task automatic next_tick(output int c, input int budget);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!tick && c < budget);
    if (!tick) c = -1;
  endtask

  task automatic measure(input logic [4:0] t, input int expp);
    int c;
    tap_sel = t;
    next_tick(c, 2*expp + 4);
    next_tick(c, 2*expp + 4);
    next_tick(c, 2*expp + 4);
    chk("tick_period", c, expp);
  endtask

  // Monitor: checks each done pulse against the front of the scoreboard.
  int   cyc = 0;
  int   gstart = 0;
  int   nticks = 0;
  logic [N-1:0] prev_gnt = '0;
  logic [N-1:0] prev_done = '0;
  logic prev_tick = 1'b0;
  exp_t me;

  always @(negedge clk) begin
    cyc++;
    if (!clr) begin
      prev_gnt  = '0;
      prev_done = '0;
      prev_tick = 1'b0;
    end else begin
      if (prev_done != '0) begin
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
      end
      if (gnt != '0 && prev_gnt == '0) begin
        gstart = cyc;
        nticks = 0;
        chk("gnt_onehot", $countones(gnt), 1);
      end else if (done != '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got %b exp none", done);
        end else begin
          me = sb.pop_front();
          chk("done_index", 32'(done), 32'(1) << me.idx);
          chk("gnt_during_done", 32'(gnt), 32'(done));
          chk("ticks_counted", nticks, me.dur);
          if (me.dur == 0) chk("zero_dur_latency", cyc - gstart, 1);
          else chk("done_after_last_tick", 32'(prev_tick), 32'd1);
        end
      end else if (gnt != '0 && tick) begin
        nticks++;
      end
      prev_gnt  = gnt;
      prev_done = done;
      prev_tick = tick;
    end
  end

  initial begin
    int           k;
    int           nt;
    logic [N-1:0] m;
    int           d[N];

    clr = 1'b0; req = '0; dur = '0; tap_sel = 5'd0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    clr = 1'b1;
    repeat (3) @(negedge clk);

    // single request, three ticks of period 2
    set_dur(0, 3);
    push_exp(pick(4'b0001, mptr), 3);
    req = 4'b0001;
    @(negedge clk);
    chk("single_gnt_latency", 32'(gnt), 32'b0001);
    serve(0, 200);

    // zero duration goes straight from LOAD to DONE
    set_dur(2, 0);
    push_exp(pick(4'b0100, mptr), 0);
    req = 4'b0100;
    @(negedge clk);
    chk("zero_gnt_latency", 32'(gnt), 32'b0100);
    serve(0, 200);

    // asynchronous reset in the middle of COUNT
    set_dur(0, 5);
    req = 4'b0001;
    wait_gnt(4'b0001, 20);
    repeat (3) @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    req = '0;
    mptr = 0;
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);

    // all requesters held, unit durations: fairness order
    for (int i = 0; i < N; i++) set_dur(i, 1);
    for (int i = 0; i < 5; i++) push_exp(pick(4'b1111, mptr), 1);
    req = 4'b1111;
    serve(5, 500);

    // abort coinciding with a tick, then a pending requester is served
    set_dur(1, 10);
    set_dur(3, 2);
    req = 4'b0010;
    wait_gnt(4'b0010, 20);
    nt = 0;
    for (int i = 0; i < 60 && nt < 3; i++) begin
      @(negedge clk);
      if (tick) nt++;
    end
    chk("abort_ticks_seen", nt, 3);
    req  = 4'b1000;
    mptr = 2;
    push_exp(pick(4'b1000, mptr), 2);
    @(negedge clk);
    chk("abort_gnt_cleared", 32'(gnt), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    serve(0, 200);

    // prescaler taps including the clamp
    measure(5'd3, 16);
    measure(5'd31, 1 << DW);
    measure(5'd9, 1 << DW);
    measure(5'd0, 2);

    // randomized episodes
    for (int e = 0; e < 25; e++) begin
      tap_sel = 5'($urandom_range(0, 2));
      for (int i = 0; i < N; i++) begin
        d[i] = $urandom_range(0, 3);
        set_dur(i, d[i]);
      end
      m = N'($urandom_range(1, (1 << N) - 1));
      req = m;
      while (m != '0) begin
        k = pick(m, mptr);
        push_exp(k, d[k]);
        m[k] = 1'b0;
      end
      serve(0, 2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
